// File: rtl/wb_classic_regfile_device.sv
// Wishbone B4 classic single-transfer responder with a small register file and programmable wait states.
// Optional macro WB_DEV_ERR_EN: unmapped addresses terminate with err_o instead of ack_o.
module wb_classic_regfile_device #(
  parameter int DAT_WIDTH   = 8,
  parameter int ADR_WIDTH   = 4,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rty_o,
  output logic                 busy_o
);

  // state | meaning
  // IDLE  | no request held; a request at this edge is captured
  // WAIT  | request held (busy); counting down, aborted if cyc/stb drops
  // RESP  | single-cycle termination on ack_o or err_o
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0]         WS_CNT  = 4'(WAIT_STATES);
  localparam logic [ADR_WIDTH:0] DEPTH_L = (ADR_WIDTH+1)'(DEPTH);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic                 we_q, we_d;
  logic [DAT_WIDTH-1:0] wdat_q, wdat_d;
  logic [DAT_WIDTH-1:0] rdat_q, rdat_d;
  logic                 ack_q, ack_d;
  logic [DAT_WIDTH-1:0] regs_q [DEPTH];
  logic                 req;
  logic                 mapped;
  logic                 commit;
`ifdef WB_DEV_ERR_EN
  logic                 err_q, err_d;
`endif

  assign req    = cyc_i && stb_i;
  assign mapped = ({1'b0, adr_q} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = '0;
    ack_d   = 1'b0;
    commit  = 1'b0;
`ifdef WB_DEV_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d   = adr_i;
          we_d    = we_i;
          wdat_d  = dat_i;
          cnt_d   = WS_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = we_q && mapped;
          rdat_d  = (!we_q && mapped) ? regs_q[adr_q] : '0;
`ifdef WB_DEV_ERR_EN
          ack_d   = mapped;
          err_d   = !mapped;
`else
          ack_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
`ifdef WB_DEV_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
`ifdef WB_DEV_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Register file commits on the same edge that enters RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else if (commit) begin
      regs_q[adr_q] <= wdat_q;
    end
  end

  assign dat_o  = rdat_q;
  assign ack_o  = ack_q;
  assign rty_o  = 1'b0;
  assign busy_o = (state_q == S_WAIT);
`ifdef WB_DEV_ERR_EN
  assign err_o  = err_q;
`else
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_classic_regfile_device.sv
// Bench for wb_classic_regfile_device: two instances (0 and 3 wait states) against a transfer-level model.
module tb_wb_classic_regfile_device;
  localparam int DEPTH = 12;
`ifdef WB_DEV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cyc, stb;
  logic       we;
  logic [3:0] adr;
  logic [7:0] wdat;
  logic [7:0] dat_o [2];
  logic [1:0] ack, err, rty, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_classic_regfile_device #(.DAT_WIDTH(8), .ADR_WIDTH(4), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr), .dat_i(wdat),
    .dat_o(dat_o[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]), .busy_o(busy[0]));

  wb_classic_regfile_device #(.DAT_WIDTH(8), .ADR_WIDTH(4), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr), .dat_i(wdat),
    .dat_o(dat_o[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]), .busy_o(busy[1]));

  function automatic int wsof(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: a captured request ages one per edge and terminates
  // once it has survived WAIT_STATES+1 further edges with cyc&stb held.
  bit         m_pend [2];
  bit         m_resp [2];
  int         m_age  [2];
  logic       m_we   [2];
  logic [3:0] m_adr  [2];
  logic [7:0] m_dat  [2];
  logic [7:0] m_mem  [2][16];
  logic       e_ack  [2];
  logic       e_err  [2];
  logic       e_busy [2];
  logic [7:0] e_dat  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_resp[i] = 0; m_age[i] = 0;
        e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0; e_dat[i] = 8'h00;
        for (int a = 0; a < 16; a++) m_mem[i][a] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_ack[i] = 0; e_err[i] = 0; e_dat[i] = 8'h00;
        if (m_resp[i]) begin
          m_resp[i] = 0;
        end else if (m_pend[i]) begin
          if (!(cyc[i] && stb[i])) begin
            m_pend[i] = 0;
          end else begin
            m_age[i]++;
            if (m_age[i] == wsof(i) + 1) begin
              m_pend[i] = 0;
              m_resp[i] = 1;
              if (int'(m_adr[i]) < DEPTH) begin
                e_ack[i] = 1;
                if (m_we[i]) m_mem[i][m_adr[i]] = m_dat[i];
                else         e_dat[i] = m_mem[i][m_adr[i]];
              end else if (ERR_EN) begin
                e_err[i] = 1;
              end else begin
                e_ack[i] = 1;
              end
            end
          end
        end else if (cyc[i] && stb[i]) begin
          m_pend[i] = 1; m_age[i] = 0;
          m_we[i] = we; m_adr[i] = adr; m_dat[i] = wdat;
        end
        e_busy[i] = m_pend[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack%0d", i),  32'(ack[i]),  32'(e_ack[i]));
      chk($sformatf("err%0d", i),  32'(err[i]),  32'(e_err[i]));
      chk($sformatf("rty%0d", i),  32'(rty[i]),  32'h0);
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i]));
      chk($sformatf("dat%0d", i),  32'(dat_o[i]), 32'(e_dat[i]));
    end
  end

  task automatic xfer(input int i, input logic w, input logic [3:0] a, input logic [7:0] d, input bit keep,
                      output logic [7:0] rd, output int lat, output int nbusy, output logic gerr);
    bit done;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we = w; adr = a; wdat = d;
    lat = 0; nbusy = 0; rd = 8'h00; gerr = 1'b0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      lat++;
      if (busy[i]) nbusy++;
      if (ack[i] || err[i]) begin
        rd = dat_o[i]; gerr = err[i]; done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout inst=%0d adr=%0h actual=no_termination expected=termination", i, a);
    end
    if (!keep) begin
      @(negedge clk);
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, nb, nterm;
    logic       ge;
    cyc = 2'b00; stb = 2'b00; we = 1'b0; adr = 4'h0; wdat = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #22;
    @(negedge clk);
    chk("reset_ack0", 32'(ack[0]), 32'h0);
    chk("reset_dat1", 32'(dat_o[1]), 32'h0);
    rst = 1'b0;

    // 1: zero wait states write then read back
    xfer(0, 1'b1, 4'd3, 8'hA5, 0, rd, lat, nb, ge);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    chk("t1_wr_busy", 32'(nb), 32'd1);
    xfer(0, 1'b0, 4'd3, 8'h00, 0, rd, lat, nb, ge);
    chk("t1_rd_dat", 32'(rd), 32'hA5);

    // 2: three wait states, read of cleared register
    xfer(1, 1'b0, 4'd0, 8'h00, 0, rd, lat, nb, ge);
    chk("t2_lat", 32'(lat), 32'd5);
    chk("t2_busy_cycles", 32'(nb), 32'd4);
    chk("t2_dat", 32'(rd), 32'h00);

    // 3: abort during wait
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 4'd5; wdat = 8'h3C;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    nterm = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) nterm++;
    end
    chk("t3_no_term", 32'(nterm), 32'd0);
    chk("t3_busy_low", 32'(busy[1]), 32'h0);
    xfer(1, 1'b0, 4'd5, 8'h00, 0, rd, lat, nb, ge);
    chk("t3_rd_dat", 32'(rd), 32'h00);

    // 4: unmapped address
    xfer(0, 1'b1, 4'd13, 8'hFF, 0, rd, lat, nb, ge);
    chk("t4_wr_err", 32'(ge), 32'(ERR_EN));
    chk("t4_wr_lat", 32'(lat), 32'd2);
    xfer(0, 1'b0, 4'd13, 8'h00, 0, rd, lat, nb, ge);
    chk("t4_rd_err", 32'(ge), 32'(ERR_EN));
    chk("t4_rd_dat", 32'(rd), 32'h00);

    // 5: back-to-back writes with strobe held
    xfer(0, 1'b1, 4'd1, 8'h11, 1, rd, lat, nb, ge);
    chk("t5_first_lat", 32'(lat), 32'd2);
    xfer(0, 1'b1, 4'd2, 8'h22, 0, rd, lat, nb, ge);
    chk("t5_second_lat", 32'(lat), 32'd3);
    xfer(0, 1'b0, 4'd1, 8'h00, 1, rd, lat, nb, ge);
    chk("t5_rd1", 32'(rd), 32'h11);
    xfer(0, 1'b0, 4'd2, 8'h00, 0, rd, lat, nb, ge);
    chk("t5_rd2", 32'(rd), 32'h22);

    // 6: async reset in the middle of a wait
    xfer(1, 1'b1, 4'd4, 8'h55, 0, rd, lat, nb, ge);
    xfer(1, 1'b0, 4'd4, 8'h00, 0, rd, lat, nb, ge);
    chk("t6_pre_rd", 32'(rd), 32'h55);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 4'd4; wdat = 8'h77;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_busy_async", 32'(busy[1]), 32'h0);
    chk("t6_ack_async", 32'(ack[1]), 32'h0);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xfer(1, 1'b0, 4'd4, 8'h00, 0, rd, lat, nb, ge);
    chk("t6_rd_cleared", 32'(rd), 32'h00);
    xfer(0, 1'b0, 4'd3, 8'h00, 0, rd, lat, nb, ge);
    chk("t6_other_cleared", 32'(rd), 32'h00);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
